keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Scans a 4x4 passive matrix keypad and produces the 16-bit active-low `buttons` vector consumed by the button-value decoder.
- Drives one column low at a time and samples the row lines through a synchroniser.
- Debounces whole-keypad frames before publishing them.
- Sits between the FPGA keypad pins and the decoder; it is the producing end of the `buttons` interface.

Parameters:
- SCAN_DIV, 1000, clk cycles each column is driven before its rows are sampled; must be >= 4.
- DEBOUNCE_SCANS, 4, number of consecutive matching full frames, after the first, required before `buttons` updates; must be >= 1.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- rows_n  input  4  keypad row lines, externally pulled up; 0 = a pressed key connects the row to the driven column.
- cols_n  output  4  keypad column drives, one-hot-low; exactly one bit is 0 at all times.
- buttons  output  16  debounced key state, active-low; bit (row*4+col) = 0 means that key is pressed.
- changed  output  1  one-cycle pulse when `buttons` takes a new value.

Behaviour:
- Reset (async on reset_n low):
  - cols_n = 4'b1110 (column 0 driven)
  - buttons = 16'hFFFF, changed = 0
  - divider = 0, column pointer = 0
  - frame and previous-frame registers = 16'hFFFF, stable count = 0
  - synchroniser flops = 4'b1111
- Reset mid-scan discards any partial frame. After release, scanning restarts at column 0 with a fresh debounce.
- Synchroniser: rows_n passes through 2 flops. Only the synchronised value is used.
- Divider: counts 0..SCAN_DIV-1 and wraps. On the cycle where divider == SCAN_DIV-1:
  - Write synced rows into frame bits {r*4+col} for r = 0..3 of the current column.
  - Advance the column pointer col -> (col+1) mod 4. cols_n is updated on the same edge.
- Column pointer state sequence: C0 -> C1 -> C2 -> C3 -> C0. cols_n = ~(1 << col).
- Frame complete = the sample taken in column C3. Frame period = 4*SCAN_DIV cycles. On frame complete, using the assembled 16-bit frame F:
  - F != previous: previous <= F, stable count <= 0.
  - F == previous and count < DEBOUNCE_SCANS: count++.
  - If this increment makes count == DEBOUNCE_SCANS and F != buttons: buttons <= F and changed = 1 on the next cycle, for exactly one cycle.
  - Count saturates at DEBOUNCE_SCANS. Further matching frames cause no update and no pulse.
- Latency: a key stable from the start of frame k is published at the completion of frame k+DEBOUNCE_SCANS, plus 1 cycle (register).
- Bounce: any frame mismatch restarts the count, so bounce shorter than DEBOUNCE_SCANS frame periods is never published.
- Multiple keys: reported as-is, with multiple zero bits. Rejecting multi-key states is the decoder's job, not this block's.
- Release: handled symmetrically. Returning to 16'hFFFF debounces the same way and pulses `changed`.
- Widths: divider is $clog2(SCAN_DIV) bits and stable count is $clog2(DEBOUNCE_SCANS+1) bits; no overflow is possible.
- Outputs: cols_n, buttons and changed are all registered; no combinational path from rows_n.

Test Plan:
All scenarios use SCAN_DIV=4, DEBOUNCE_SCANS=2 and a keypad model: rows_n[r] = 0 iff key(r,c) is held and cols_n[c] = 0.
- Reset: hold reset_n=0, then release.
  - Required: cols_n=4'b1110, buttons=16'hFFFF, changed=0.
  - Required: cols_n steps 1110 -> 1101 -> 1011 -> 0111 every 4 cycles, then wraps.
- Single press: hold key row 1, col 2 from a frame boundary.
  - Required: buttons=16'hFFBF (bit 6 low; decoder yields 7) after the 3rd complete frame.
  - Required: changed high for exactly 1 cycle, with no further pulses while the key is held.
- Release: release that key.
  - Required: buttons returns to 16'hFFFF after 3 frames, with one changed pulse.
- Bounce: toggle key row 0, col 0 every frame for 6 frames, then hold it.
  - Required: no update during toggling.
  - Required: buttons=16'hFFFE 3 frames after it becomes steady.
- Two keys: hold (3,3) and (0,1) together.
  - Required: buttons=16'h7FFD.
- Reset mid-scan: assert reset_n=0 in the middle of the debounce of a press.
  - Required: outputs return to their reset values immediately.
  - Required: after release, a full 3-frame debounce is needed again before buttons updates.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks a low column drive across the keypad,
// samples synchronised rows and publishes debounced whole-keypad frames.
module keypad_scanner #(
   parameter int SCAN_DIV       = 1000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [3:0]  rows_n,
   output logic [3:0]  cols_n,
   output logic [15:0] buttons,
   output logic        changed
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);

   typedef enum logic [1:0] {C0, C1, C2, C3} col_t;

   col_t             col, col_next;
   logic [DIV_W-1:0] divider;
   logic [3:0]       sync_a, sync_b;
   logic [3:0]       cols_next;
   logic [15:0]      frame, frame_next, prev_frame;
   logic [CNT_W-1:0] stable_count;
   logic             sample, frame_done;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_a <= 4'b1111;
         sync_b <= 4'b1111;
      end else begin
         sync_a <= rows_n;
         sync_b <= sync_a;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         divider <= '0;
      else if (sample)
         divider <= '0;
      else
         divider <= divider + DIV_W'(1);
   end

   assign sample = (divider == DIV_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         col    <= C0;
         cols_n <= 4'b1110;
      end else if (sample) begin
         col    <= col_next;
         cols_n <= cols_next;
      end
   end

   // Next column and its drive pattern; the last column closes a frame.
   always_comb begin
      col_next   = col;
      cols_next  = 4'b1110;
      frame_done = 1'b0;
      case (col)
         C0: begin col_next = C1; cols_next = 4'b1101; end
         C1: begin col_next = C2; cols_next = 4'b1011; end
         C2: begin col_next = C3; cols_next = 4'b0111; end
         C3: begin col_next = C0; cols_next = 4'b1110; frame_done = sample; end
         default: begin col_next = C0; cols_next = 4'b1110; end
      endcase
   end

   always_comb begin
      frame_next = frame;
      for (int r = 0; r < 4; r++)
         frame_next[r*4 + int'(col)] = sync_b[r];
   end

   // A frame must repeat DEBOUNCE_SCANS times after its first sighting before it is published.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frame        <= 16'hFFFF;
         prev_frame   <= 16'hFFFF;
         stable_count <= '0;
         buttons      <= 16'hFFFF;
         changed      <= 1'b0;
      end else begin
         changed <= 1'b0;
         if (sample)
            frame <= frame_next;
         if (frame_done) begin
            if (frame_next != prev_frame) begin
               prev_frame   <= frame_next;
               stable_count <= '0;
            end else if (stable_count < CNT_MAX) begin
               stable_count <= stable_count + CNT_W'(1);
               if ((stable_count + CNT_W'(1) == CNT_MAX) && (frame_next != buttons)) begin
                  buttons <= frame_next;
                  changed <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a keypad model drives rows_n and a
// run-length frame model predicts cols_n, buttons and changed every cycle.
module tb_keypad_scanner;

   localparam int SCAN_DIV = 4;
   localparam int DEB      = 2;
   localparam int FRAME    = 4 * SCAN_DIV;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [3:0]  rows_n;
   logic [3:0]  cols_n;
   logic [15:0] buttons;
   logic        changed;

   logic [15:0] held = 16'h0000;
   int compared = 0;
   int mismatched = 0;
   int cyc = 0;
   int changed_count = 0;

   logic [15:0] last_frame, exp_buttons, model_frame;
   logic [3:0]  exp_cols;
   logic        exp_changed;
   int          run_len;

   always #5 clk = ~clk;

   keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .rows_n (rows_n),
      .cols_n (cols_n),
      .buttons(buttons),
      .changed(changed)
   );

   // A held key pulls its row low only while its column is driven.
   always_comb begin
      rows_n = 4'b1111;
      for (int r = 0; r < 4; r++)
         rows_n[r] = ~|(held[r*4 +: 4] & ~cols_n);
   end

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, wanted %h (cycle %0d, t=%0t)", name, actual, expected, cyc, $time);
      end
   endtask

   task automatic applyStimulus(input logic [15:0] keys);
      held = keys;
   endtask

   task automatic waitFrames(input int n);
      int seen = 0;
      int guard = 0;
      while (seen < n && guard < n * FRAME + 64) begin
         @(negedge clk);
         #1;
         guard++;
         if (reset_n && cyc > 0 && cyc % FRAME == 0)
            seen++;
      end
      if (seen < n) begin
         mismatched++;
         $display("[TB] FAIL frame_wait: saw %0d frames, wanted %0d", seen, n);
      end
   endtask

   // Model: column = (cycles / SCAN_DIV) mod 4; a frame is published when it
   // has appeared DEB+1 times in a row (reset counts as one all-released frame).
   initial begin
      last_frame  = 16'hFFFF;
      exp_buttons = 16'hFFFF;
      run_len     = 1;
      forever begin
         @(negedge clk);
         exp_changed = 1'b0;
         if (!reset_n) begin
            cyc         = 0;
            last_frame  = 16'hFFFF;
            exp_buttons = 16'hFFFF;
            run_len     = 1;
            exp_cols    = 4'b1110;
         end else begin
            cyc++;
            exp_cols = 4'b1111 ^ (4'b0001 << ((cyc / SCAN_DIV) % 4));
            if (cyc % FRAME == 0) begin
               model_frame = ~held;
               if (model_frame == last_frame)
                  run_len++;
               else begin
                  last_frame = model_frame;
                  run_len    = 1;
               end
               if (run_len == DEB + 1 && model_frame != exp_buttons) begin
                  exp_buttons = model_frame;
                  exp_changed = 1'b1;
               end
            end
         end
         checkOutput("cols_n", {12'h000, cols_n}, {12'h000, exp_cols});
         checkOutput("buttons", buttons, exp_buttons);
         checkOutput("changed", {15'h0000, changed}, {15'h0000, exp_changed});
         if (changed === 1'b1)
            changed_count++;
      end
   end

   initial begin
      logic [3:0] walk [4];
      int base;
      walk[0] = 4'b1101;
      walk[1] = 4'b1011;
      walk[2] = 4'b0111;
      walk[3] = 4'b1110;

      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checkOutput("reset_cols", {12'h000, cols_n}, 16'h000E);
      checkOutput("reset_buttons", buttons, 16'hFFFF);
      checkOutput("reset_changed", {15'h0000, changed}, 16'h0000);
      reset_n = 1'b1;

      for (int i = 0; i < 4; i++) begin
         repeat (SCAN_DIV) begin
            @(negedge clk);
            #1;
         end
         checkOutput("col_walk", {12'h000, cols_n}, {12'h000, walk[i]});
      end

      $display("[TB] single press row 1 col 2");
      base = changed_count;
      applyStimulus(16'h0040);
      waitFrames(2);
      checkOutput("press_early", buttons, 16'hFFFF);
      waitFrames(1);
      checkOutput("press_buttons", buttons, 16'hFFBF);
      checkOutput("press_pulses", 16'(changed_count - base), 16'd1);
      waitFrames(2);
      checkOutput("press_held_pulses", 16'(changed_count - base), 16'd1);

      $display("[TB] release");
      base = changed_count;
      applyStimulus(16'h0000);
      waitFrames(3);
      checkOutput("release_buttons", buttons, 16'hFFFF);
      checkOutput("release_pulses", 16'(changed_count - base), 16'd1);

      $display("[TB] bounce on row 0 col 0");
      base = changed_count;
      for (int i = 0; i < 6; i++) begin
         applyStimulus((i % 2 == 0) ? 16'h0001 : 16'h0000);
         waitFrames(1);
      end
      checkOutput("bounce_buttons", buttons, 16'hFFFF);
      checkOutput("bounce_pulses", 16'(changed_count - base), 16'd0);
      applyStimulus(16'h0001);
      waitFrames(3);
      checkOutput("steady_buttons", buttons, 16'hFFFE);
      checkOutput("steady_pulses", 16'(changed_count - base), 16'd1);

      $display("[TB] two keys (3,3) and (0,1)");
      applyStimulus(16'h8002);
      waitFrames(3);
      checkOutput("two_keys", buttons, 16'h7FFD);

      $display("[TB] reset during debounce");
      applyStimulus(16'h0000);
      waitFrames(3);
      checkOutput("clear_before_reset", buttons, 16'hFFFF);
      applyStimulus(16'h0200);
      waitFrames(2);
      repeat (6) @(negedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      checkOutput("midreset_cols", {12'h000, cols_n}, 16'h000E);
      checkOutput("midreset_buttons", buttons, 16'hFFFF);
      checkOutput("midreset_changed", {15'h0000, changed}, 16'h0000);
      repeat (3) @(negedge clk);
      #1;
      reset_n = 1'b1;
      waitFrames(2);
      checkOutput("after_reset_early", buttons, 16'hFFFF);
      waitFrames(1);
      checkOutput("after_reset_buttons", buttons, 16'hFDFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #100000;
      mismatched++;
      $display("[TB] FAIL watchdog: time %0t exceeded", $time);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
